// File: rtl/knight_pkg.sv
// knight_pkg: shared types and constants for the Knight action sequencer.
// Holds state/status encodings, keycodes and the registered output bundle.
package knight_pkg;

    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WALK,
        ST_RISE,
        ST_FALL,
        ST_ATTACK,
        ST_HURT,
        ST_DEAD
    } state_e;

    typedef enum logic [3:0] {
        STAT_IDLE    = 4'd0,
        STAT_WALK    = 4'd1,
        STAT_JUMP_UP = 4'd2,
        STAT_DOWN    = 4'd3,
        STAT_ATTACK  = 4'd4,
        STAT_HURT    = 4'd5,
        STAT_DEAD    = 4'd6
    } status_e;

    localparam logic [7:0] KEY_LEFT   = 8'h50;
    localparam logic [7:0] KEY_RIGHT  = 8'h4F;
    localparam logic [7:0] KEY_JUMP   = 8'h52;
    localparam logic [7:0] KEY_DOWN   = 8'h51;
    localparam logic [7:0] KEY_ATTACK = 8'h1B;

    typedef logic signed [9:0] step_t;

    typedef struct packed {
        step_t   x_step;
        step_t   y_step;
        status_e status;
        logic    inverse;
        logic    attack_active;
        logic    invuln;
    } out_t;

endpackage

// File: rtl/knight_action_ctrl_if.sv
// knight_action_ctrl_if: per-frame player inputs and step/status commands
// between the game logic (master) and the action sequencer (slave).
interface knight_action_ctrl_if;
    logic [7:0]        keycode;
    logic              on_ground;
    logic              hit;
    logic              respawn;
    logic [3:0]        life;
    logic signed [9:0] x_step;
    logic signed [9:0] y_step;
    logic [3:0]        status;
    logic              inverse;
    logic              attack_active;
    logic              invuln;

    modport master (
        output keycode, on_ground, hit, respawn, life,
        input  x_step, y_step, status, inverse, attack_active, invuln
    );

    modport slave (
        input  keycode, on_ground, hit, respawn, life,
        output x_step, y_step, status, inverse, attack_active, invuln
    );
endinterface

// File: rtl/frame_countdown.sv
// frame_countdown: loadable frame counter that counts down once per tick
// and saturates at zero.
module frame_countdown
    import knight_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (tick_i && count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/knight_action_ctrl.sv
// knight_action_ctrl: per-frame attack/jump/walk/hurt/death arbitration for the Knight.
// Build option: define KNIGHT_DOUBLE_JUMP_EN to allow one extra jump per airtime.
module knight_action_ctrl
    import knight_pkg::*;
#(
    parameter int WALK_STEP       = 2,
    parameter int JUMP_STEP       = 6,
    parameter int JUMP_FRAMES     = 27,
    parameter int ATTACK_FRAMES   = 8,
    parameter int ATTACK_COOLDOWN = 12,
    parameter int HURT_FRAMES     = 30
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    knight_action_ctrl_if.slave  bus
);

    localparam step_t WALK_POS = step_t'(WALK_STEP);
    localparam step_t WALK_NEG = -step_t'(WALK_STEP);
    localparam step_t JUMP_POS = step_t'(JUMP_STEP);

    state_e state_q;
    out_t   out_q;

    logic [CNT_W-1:0] rise_cnt, atk_cnt, cool_cnt, hurt_cnt;
    logic             rise_zero, atk_zero, cool_zero, hurt_zero;
    logic             rise_last, atk_last, cool_last, hurt_last;
    logic [7:0]       key_eff;
    logic             dead_go, respawn_go, hurt_go, no_override, mobile;
    logic             hurt_done, atk_done, atk_go, jump_go, dj_go, rise_keep;

    function automatic out_t idle_out(input logic inv);
        idle_out = '{x_step: '0, y_step: '0, status: STAT_IDLE, inverse: inv,
                     attack_active: 1'b0, invuln: 1'b0};
    endfunction

    function automatic out_t rise_out(input logic inv);
        rise_out        = idle_out(inv);
        rise_out.y_step = -JUMP_POS;
        rise_out.status = STAT_JUMP_UP;
    endfunction

    function automatic out_t fall_out(input logic [7:0] key, input logic inv);
        fall_out        = idle_out(inv);
        fall_out.y_step = JUMP_POS;
        fall_out.status = STAT_DOWN;
        if (key == KEY_LEFT) begin
            fall_out.x_step  = WALK_NEG;
            fall_out.inverse = 1'b1;
        end else if (key == KEY_RIGHT) begin
            fall_out.x_step  = WALK_POS;
            fall_out.inverse = 1'b0;
        end
    endfunction

    function automatic step_t gravity(input logic grounded);
        gravity = grounded ? '0 : JUMP_POS;
    endfunction

    // A counter at 1 is in its final frame; decisions fire then so windows last exactly N frames.
    assign rise_last = rise_zero || rise_cnt == CNT_W'(1);
    assign atk_last  = atk_zero  || atk_cnt  == CNT_W'(1);
    assign cool_last = cool_zero || cool_cnt == CNT_W'(1);
    assign hurt_last = hurt_zero || hurt_cnt == CNT_W'(1);

    assign key_eff     = (bus.keycode == KEY_ATTACK) ? 8'h00 : bus.keycode;
    assign dead_go     = (state_q == ST_DEAD) || (bus.life == '0);
    assign respawn_go  = !dead_go && bus.respawn;
    assign hurt_go     = !dead_go && !bus.respawn && bus.hit && !out_q.invuln;
    assign no_override = !dead_go && !bus.respawn && !hurt_go;
    assign mobile      = state_q inside {ST_IDLE, ST_WALK, ST_RISE, ST_FALL};
    assign hurt_done   = no_override && state_q == ST_HURT && hurt_last;
    assign atk_done    = no_override && state_q == ST_ATTACK && atk_last;
    assign atk_go      = no_override && mobile && bus.keycode == KEY_ATTACK && cool_last;
    assign jump_go     = no_override && !atk_go && state_q inside {ST_IDLE, ST_WALK}
                         && bus.on_ground && key_eff == KEY_JUMP;
    assign rise_keep   = state_q == ST_RISE && key_eff == KEY_JUMP && !rise_last;

`ifdef KNIGHT_DOUBLE_JUMP_EN
    logic [7:0] prev_key_q;
    logic       air_jump_avail_q;

    assign dj_go = no_override && !atk_go && key_eff == KEY_JUMP && prev_key_q != KEY_JUMP
                   && air_jump_avail_q
                   && (state_q == ST_RISE || (state_q == ST_FALL && !bus.on_ground));

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            prev_key_q       <= '0;
            air_jump_avail_q <= 1'b1;
        end else begin
            prev_key_q <= bus.keycode;
            if (dj_go) begin
                air_jump_avail_q <= 1'b0;
            end else if (bus.on_ground || bus.respawn) begin
                air_jump_avail_q <= 1'b1;
            end
        end
    end
`else
    assign dj_go = 1'b0;
`endif

    frame_countdown u_rise_cnt (
        .clk(frame_clk), .rst(Reset), .load_i(jump_go || dj_go),
        .load_val_i(CNT_W'(JUMP_FRAMES)), .tick_i(1'b1), .count_o(rise_cnt), .zero_o(rise_zero)
    );

    frame_countdown u_atk_cnt (
        .clk(frame_clk), .rst(Reset), .load_i(atk_go || hurt_go || respawn_go),
        .load_val_i(atk_go ? CNT_W'(ATTACK_FRAMES) : '0), .tick_i(1'b1),
        .count_o(atk_cnt), .zero_o(atk_zero)
    );

    frame_countdown u_cool_cnt (
        .clk(frame_clk), .rst(Reset), .load_i(atk_done || respawn_go),
        .load_val_i(atk_done ? CNT_W'(ATTACK_COOLDOWN) : '0), .tick_i(1'b1),
        .count_o(cool_cnt), .zero_o(cool_zero)
    );

    frame_countdown u_hurt_cnt (
        .clk(frame_clk), .rst(Reset), .load_i(hurt_go || respawn_go),
        .load_val_i(hurt_go ? CNT_W'(HURT_FRAMES) : '0), .tick_i(1'b1),
        .count_o(hurt_cnt), .zero_o(hurt_zero)
    );

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            out_q   <= idle_out(1'b0);
        end else if (dead_go) begin
            state_q <= ST_DEAD;
            out_q   <= '{x_step: '0, y_step: '0, status: STAT_DEAD, inverse: out_q.inverse,
                         attack_active: 1'b0, invuln: 1'b0};
        end else if (respawn_go) begin
            state_q <= ST_IDLE;
            out_q   <= idle_out(out_q.inverse);
        end else if (hurt_go) begin
            state_q <= ST_HURT;
            out_q   <= '{x_step: out_q.inverse ? WALK_POS : WALK_NEG,
                         y_step: gravity(bus.on_ground), status: STAT_HURT,
                         inverse: out_q.inverse, attack_active: 1'b0, invuln: 1'b1};
        end else begin
            case (state_q)
                ST_HURT, ST_ATTACK: begin
                    if (hurt_done || atk_done) begin
                        state_q <= bus.on_ground ? ST_IDLE : ST_FALL;
                        out_q   <= bus.on_ground ? idle_out(out_q.inverse)
                                                 : fall_out(8'h00, out_q.inverse);
                    end else begin
                        out_q.y_step <= gravity(bus.on_ground);
                    end
                end
                default: begin
                    if (atk_go) begin
                        state_q <= ST_ATTACK;
                        out_q   <= '{x_step: '0, y_step: gravity(bus.on_ground),
                                     status: STAT_ATTACK, inverse: out_q.inverse,
                                     attack_active: 1'b1, invuln: 1'b0};
                    end else if (jump_go || dj_go || rise_keep) begin
                        state_q <= ST_RISE;
                        out_q   <= rise_out(out_q.inverse);
                    end else if (state_q == ST_RISE || !bus.on_ground) begin
                        state_q <= ST_FALL;
                        out_q   <= fall_out(key_eff, out_q.inverse);
                    end else if (state_q == ST_FALL
                                 || !(key_eff == KEY_LEFT || key_eff == KEY_RIGHT)) begin
                        state_q <= ST_IDLE;
                        out_q   <= idle_out(out_q.inverse);
                    end else begin
                        state_q <= ST_WALK;
                        out_q   <= '{x_step: (key_eff == KEY_LEFT) ? WALK_NEG : WALK_POS,
                                     y_step: '0, status: STAT_WALK,
                                     inverse: (key_eff == KEY_LEFT), attack_active: 1'b0,
                                     invuln: 1'b0};
                    end
                end
            endcase
        end
    end

    assign bus.x_step        = out_q.x_step;
    assign bus.y_step        = out_q.y_step;
    assign bus.status        = out_q.status;
    assign bus.inverse       = out_q.inverse;
    assign bus.attack_active = out_q.attack_active;
    assign bus.invuln        = out_q.invuln;

endmodule

// File: tb/tb_knight_action_ctrl.sv
// tb_knight_action_ctrl: directed and random frames against a behavioural Knight model,
// expected outputs queued per frame and compared by an independent monitor.
module tb_knight_action_ctrl;

    localparam int WALK = 2;
    localparam int JUMP = 6;
    localparam int JFR  = 27;
    localparam int AFR  = 8;
    localparam int ACD  = 12;
    localparam int HFR  = 30;

    typedef struct packed {
        logic signed [9:0] x;
        logic signed [9:0] y;
        logic [3:0]        st;
        logic              inv;
        logic              atk;
        logic              iv;
    } obs_t;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    knight_action_ctrl_if bus ();

    knight_action_ctrl dut (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .bus      (bus)
    );

    always #5 frame_clk = ~frame_clk;

    obs_t exp_q[$];
    int   fno_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   frame_no = 0;

    // Behavioural model: a named mode plus "frames remaining" budgets for each timed window.
    string m_mode;
    int    rise_left, atk_left, cool_left, hurt_left;
    obs_t  m;
`ifdef KNIGHT_DOUBLE_JUMP_EN
    bit         air_avail;
    logic [7:0] prev_kc;
`endif

    function automatic string fmt(input obs_t o);
        return $sformatf("x=%0d y=%0d st=%0d inv=%0b atk=%0b iv=%0b",
                         $signed(o.x), $signed(o.y), o.st, o.inv, o.atk, o.iv);
    endfunction

    task automatic check(input string name, input bit ok, input string got_s, input string want_s);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, got_s, want_s);
    endtask

    task automatic m_idle();
        m_mode = "idle";
        m.x = '0; m.y = '0; m.st = 4'd0; m.atk = 1'b0; m.iv = 1'b0;
    endtask

    task automatic m_fall(input logic [7:0] k);
        m_mode = "fall";
        m.x = '0; m.y = 10'(JUMP); m.st = 4'd3; m.atk = 1'b0; m.iv = 1'b0;
        if (k == 8'h50) begin m.x = 10'(-WALK); m.inv = 1'b1; end
        if (k == 8'h4F) begin m.x = 10'(WALK);  m.inv = 1'b0; end
    endtask

    task automatic m_settle(input bit og);
        if (og) m_idle();
        else    m_fall(8'h00);
    endtask

    task automatic m_rise();
        m_mode = "rise";
        rise_left = JFR;
        m.x = '0; m.y = 10'(-JUMP); m.st = 4'd2; m.atk = 1'b0; m.iv = 1'b0;
    endtask

    task automatic model_step(input bit rst, input logic [7:0] kc, input bit og,
                              input bit ht, input bit rs, input logic [3:0] lf);
        logic [7:0] k;
        bit         dj;
        if (rst) begin
            rise_left = 0; atk_left = 0; cool_left = 0; hurt_left = 0;
            m.inv = 1'b0;
            m_idle();
`ifdef KNIGHT_DOUBLE_JUMP_EN
            air_avail = 1'b1; prev_kc = 8'h00;
`endif
            return;
        end
        if (rise_left > 0) rise_left--;
        if (atk_left  > 0) atk_left--;
        if (cool_left > 0) cool_left--;
        if (hurt_left > 0) hurt_left--;
        dj = 1'b0;
        k  = kc;
        if (m_mode == "dead" || lf == 4'd0) begin
            m_mode = "dead";
            m.x = '0; m.y = '0; m.st = 4'd6; m.atk = 1'b0; m.iv = 1'b0;
        end else if (rs) begin
            atk_left = 0; cool_left = 0; hurt_left = 0;
            m_idle();
        end else if (ht && !m.iv) begin
            m_mode = "hurt";
            atk_left = 0; hurt_left = HFR;
            m.x = m.inv ? 10'(WALK) : 10'(-WALK);
            m.y = og ? 10'(0) : 10'(JUMP);
            m.st = 4'd5; m.atk = 1'b0; m.iv = 1'b1;
        end else if (m_mode == "hurt") begin
            if (hurt_left == 0) m_settle(og);
            else m.y = og ? 10'(0) : 10'(JUMP);
        end else if (m_mode == "attack") begin
            if (atk_left == 0) begin
                cool_left = ACD;
                m_settle(og);
            end else begin
                m.y = og ? 10'(0) : 10'(JUMP);
            end
        end else if (kc == 8'h1B && cool_left == 0) begin
            m_mode = "attack";
            atk_left = AFR;
            m.x = '0; m.y = og ? 10'(0) : 10'(JUMP); m.st = 4'd4; m.atk = 1'b1; m.iv = 1'b0;
        end else begin
            if (kc == 8'h1B) k = 8'h00;
`ifdef KNIGHT_DOUBLE_JUMP_EN
            if ((m_mode == "rise" || (m_mode == "fall" && !og)) && k == 8'h52
                && prev_kc != 8'h52 && air_avail) dj = 1'b1;
`endif
            if (dj || ((m_mode == "idle" || m_mode == "walk") && og && k == 8'h52)) m_rise();
            else if (m_mode == "rise" && k == 8'h52 && rise_left > 0) begin
                m.x = '0; m.y = 10'(-JUMP); m.st = 4'd2;
            end else if (m_mode == "rise" || !og) m_fall(k);
            else if (m_mode == "fall") m_idle();
            else if (k == 8'h50 || k == 8'h4F) begin
                m_mode = "walk";
                m.x = (k == 8'h50) ? 10'(-WALK) : 10'(WALK);
                m.inv = (k == 8'h50);
                m.y = '0; m.st = 4'd1; m.atk = 1'b0; m.iv = 1'b0;
            end else m_idle();
        end
`ifdef KNIGHT_DOUBLE_JUMP_EN
        if (dj) air_avail = 1'b0;
        else if (og || rs) air_avail = 1'b1;
        prev_kc = kc;
`endif
    endtask

    task automatic drive(input bit rst, input logic [7:0] kc, input bit og,
                         input bit ht, input bit rs, input logic [3:0] lf);
        @(negedge frame_clk);
        Reset          = rst;
        bus.keycode    = kc;
        bus.on_ground  = og;
        bus.hit        = ht;
        bus.respawn    = rs;
        bus.life       = lf;
        model_step(rst, kc, og, ht, rs, lf);
        exp_q.push_back(m);
        fno_q.push_back(frame_no);
        frame_no++;
    endtask

    task automatic frame(input logic [7:0] kc, input bit og, input bit ht = 1'b0,
                         input bit rs = 1'b0, input logic [3:0] lf = 4'd3);
        drive(1'b0, kc, og, ht, rs, lf);
    endtask

    task automatic frames(input int n, input logic [7:0] kc, input bit og);
        for (int i = 0; i < n; i++) frame(kc, og);
    endtask

    // Monitor: every frame's outputs are compared against the oldest queued expectation.
    initial begin
        forever begin
            @(posedge frame_clk);
            #1;
            if (exp_q.size() > 0) begin
                obs_t want, got;
                int   fno;
                want = exp_q.pop_front();
                fno  = fno_q.pop_front();
                got  = '{bus.x_step, bus.y_step, bus.status, bus.inverse,
                         bus.attack_active, bus.invuln};
                check($sformatf("frame%0d", fno), got === want, fmt(got), fmt(want));
            end
        end
    end

    initial begin
        logic [7:0] kc;
        logic [3:0] lf;
        bit         og, ht, rs, rst;
        bus.keycode = 8'h00; bus.on_ground = 1'b1; bus.hit = 1'b0;
        bus.respawn = 1'b0;  bus.life = 4'd3;

        // Reset, walk right, stop.
        drive(1'b1, 8'h4F, 1'b1, 1'b1, 1'b0, 4'd3);
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 4'd3);
        frames(3, 8'h4F, 1'b1);
        frames(2, 8'h00, 1'b1);

        // Full-height jump, landing, then a short hop released after 10 frames.
        frame(8'h52, 1'b1);
        frames(34, 8'h52, 1'b0);
        frames(2, 8'h00, 1'b1);
        frame(8'h52, 1'b1);
        frames(9, 8'h52, 1'b0);
        frames(3, 8'h00, 1'b0);
        frames(2, 8'h00, 1'b1);

        // Held attack: window, cooldown, next swing; then attack aborting a rise.
        frames(45, 8'h1B, 1'b1);
        frames(14, 8'h00, 1'b1);
        frame(8'h52, 1'b1);
        frames(3, 8'h52, 1'b0);
        frames(9, 8'h1B, 1'b0);
        frames(2, 8'h00, 1'b0);
        frames(2, 8'h00, 1'b1);

        // Hit facing right: knockback, ignored re-hit, re-entry after invulnerability.
        frame(8'h4F, 1'b1);
        frames(14, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++) frame(8'h00, 1'b1, (i == 0 || i == 10 || i == 30 || i == 31));
        frames(32, 8'h00, 1'b1);
        // Hit facing left while airborne.
        frame(8'h50, 1'b1);
        frame(8'h00, 1'b0, 1'b1);
        frames(3, 8'h00, 1'b0);
        frames(30, 8'h00, 1'b1);

        // Walk off the platform with air control, then down key forcing a fall mid-rise.
        frames(2, 8'h50, 1'b1);
        frames(3, 8'h50, 1'b0);
        frame(8'h00, 1'b1);
        frame(8'h52, 1'b1);
        frames(2, 8'h52, 1'b0);
        frames(2, 8'h51, 1'b0);
        frame(8'h00, 1'b1);

        // Air press after release: double jump only when the build enables it.
        frame(8'h52, 1'b1);
        frames(2, 8'h52, 1'b0);
        frames(2, 8'h00, 1'b0);
        frames(3, 8'h52, 1'b0);
        frames(2, 8'h00, 1'b0);
        frames(2, 8'h52, 1'b0);
        frames(2, 8'h00, 1'b1);

        // Respawn clears attack, cooldown and invulnerability.
        frames(3, 8'h1B, 1'b1);
        frame(8'h00, 1'b1, 1'b0, 1'b1);
        frame(8'h1B, 1'b1);
        frame(8'h00, 1'b1, 1'b1);
        frame(8'h00, 1'b1, 1'b0, 1'b1);
        frame(8'h00, 1'b1, 1'b1);
        frames(31, 8'h00, 1'b1);

        // Death mid-attack is absorbing until Reset.
        frames(3, 8'h1B, 1'b1);
        frame(8'h1B, 1'b1, 1'b0, 1'b0, 4'd0);
        frame(8'h52, 1'b1, 1'b1, 1'b0, 4'd3);
        frame(8'h4F, 1'b0, 1'b0, 1'b1, 4'd3);
        frames(2, 8'h1B, 1'b1);
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 4'd3);
        frames(2, 8'h4F, 1'b1);

        // Random play.
        kc = 8'h00; og = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 7))
                    0: kc = 8'h50;
                    1: kc = 8'h4F;
                    2, 3: kc = 8'h52;
                    4: kc = 8'h1B;
                    5: kc = 8'h51;
                    6: kc = 8'h00;
                    default: kc = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 7) == 0) og = ~og;
            ht  = ($urandom_range(0, 24) == 0);
            rs  = ($urandom_range(0, 149) == 0);
            lf  = ($urandom_range(0, 599) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rst = ($urandom_range(0, 399) == 0) || (m_mode == "dead" && $urandom_range(0, 9) == 0);
            drive(rst, kc, og, ht, rs, lf);
        end

        @(posedge frame_clk);
        #2;
        check("drain", exp_q.size() == 0, $sformatf("%0d pending", exp_q.size()), "0 pending");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
